// File: rtl/cd_tx_frame_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cd_tx_frame_pkg : shared CRC constants, frame header offsets, framer states
// Rev 1.0
// ----------------------------------------------------------------------------
package cd_tx_frame_pkg;

  localparam logic [15:0] CRC_POLY = 16'hA001;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam logic [7:0] HDR_SRC  = 8'd0;
  localparam logic [7:0] HDR_DST  = 8'd1;
  localparam logic [7:0] HDR_LEN  = 8'd2;
  localparam logic [7:0] HDR_SIZE = 8'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SEND  = 3'd3,
    ST_CRC_L = 3'd4,
    ST_CRC_H = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cd_crc16.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cd_crc16 : combinational single-byte CRC-16/MODBUS update (reflected)
// Rev 1.0
// ----------------------------------------------------------------------------
module cd_crc16
  import cd_tx_frame_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule
`default_nettype wire

// File: rtl/cd_tx_frame.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cd_tx_frame : reads a frame from the TX RAM, streams it byte-wise, appends CRC
// Rev 1.0
// ----------------------------------------------------------------------------
module cd_tx_frame
  import cd_tx_frame_pkg::*;
#(
  parameter int MAX_LEN = 253
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       unread,
  input  logic [7:0] rd_byte,
  output logic [7:0] rd_addr,
  output logic       rd_en,
  output logic       rd_done,
  input  logic       tx_permit,
  input  logic       abort,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
);

  localparam logic [7:0] LEN_CAP = 8'(MAX_LEN);

  state_t      state;
  logic [15:0] crc;
  logic [15:0] crc_next;
  logic [7:0]  idx;
  logic [7:0]  len;
  logic [7:0]  last_idx;

  // len is clamped so this never wraps
  assign last_idx = len + (HDR_SIZE - 8'd1);

  cd_crc16 u_crc (
    .crc_in  (crc),
    .data    (rd_byte),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      crc      <= CRC_INIT;
      idx      <= 8'd0;
      len      <= 8'd0;
      rd_addr  <= 8'd0;
      rd_en    <= 1'b0;
      rd_done  <= 1'b0;
      tx_data  <= 8'd0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rd_en   <= 1'b0;
      rd_done <= 1'b0;
      if (abort && state != ST_IDLE && state != ST_DONE) begin
        state    <= ST_IDLE;
        tx_valid <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (unread && tx_permit && !abort) begin
              idx     <= HDR_SRC;
              len     <= 8'd0;
              crc     <= CRC_INIT;
              rd_addr <= HDR_SRC;
              rd_en   <= 1'b1;
              busy    <= 1'b1;
              state   <= ST_READ;
            end
          end
          ST_READ: state <= ST_LOAD;
          ST_LOAD: begin
            tx_data  <= rd_byte;
            tx_valid <= 1'b1;
            crc      <= crc_next;
            if (idx == HDR_LEN) begin
              len <= (rd_byte > LEN_CAP) ? LEN_CAP : rd_byte;
            end
            state <= ST_SEND;
          end
          ST_SEND: begin
            if (tx_ready) begin
              // before the length byte is loaded the end compare is meaningless
              if (idx >= HDR_LEN && idx == last_idx) begin
                tx_data <= crc[7:0];
                state   <= ST_CRC_L;
              end else begin
                idx      <= idx + 8'd1;
                rd_addr  <= idx + 8'd1;
                rd_en    <= 1'b1;
                tx_valid <= 1'b0;
                state    <= ST_READ;
              end
            end
          end
          ST_CRC_L: begin
            if (tx_ready) begin
              tx_data <= crc[15:8];
              state   <= ST_CRC_H;
            end
          end
          ST_CRC_H: begin
            if (tx_ready) begin
              tx_valid <= 1'b0;
              rd_done  <= 1'b1;
              state    <= ST_DONE;
            end
          end
          ST_DONE: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cd_tx_frame.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cd_tx_frame : directed self-checking bench for the TX framer
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_cd_tx_frame;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       unread;
  logic [7:0] rd_byte = 8'd0;
  logic [7:0] rd_addr;
  logic       rd_en;
  logic       rd_done;
  logic       tx_permit;
  logic       abort;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;

  logic [7:0] mem [256];
  logic [7:0] q [$];
  logic [7:0] exp_q [$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         done_cnt = 0;
  int         max_addr = 0;
  int         first_addr = -1;
  int         stab_err = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;

  always #5 clk = ~clk;

  cd_tx_frame dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .unread    (unread),
    .rd_byte   (rd_byte),
    .rd_addr   (rd_addr),
    .rd_en     (rd_en),
    .rd_done   (rd_done),
    .tx_permit (tx_permit),
    .abort     (abort),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy)
  );

  // synchronous-read RAM model
  always @(posedge clk) begin
    if (rd_en) rd_byte <= mem[rd_addr];
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(tx_valid && tx_data == prev_data)) stab_err++;
      prev_stall = tx_valid && !tx_ready && !abort;
      prev_data  = tx_data;
      if (tx_valid && tx_ready) q.push_back(tx_data);
      if (rd_done) done_cnt++;
      if (rd_en) begin
        if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
        if (first_addr < 0) first_addr = int'(rd_addr);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = c >> 1;
      if (fb) c = c ^ 16'hA001;
    end
    return c;
  endfunction

  task automatic build_exp();
    int          l;
    logic [15:0] c;
    exp_q.delete();
    l = (mem[2] > 8'd253) ? 253 : int'(mem[2]);
    c = 16'hFFFF;
    for (int i = 0; i < l + 3; i++) begin
      exp_q.push_back(mem[i]);
      c = crc_step(c, mem[i]);
    end
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
  endtask

  task automatic compare_stream(input string tag);
    logic [15:0] r;
    check({tag, "_count"}, q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), {24'd0, q[i]}, {24'd0, exp_q[i]});
    r = 16'hFFFF;
    for (int i = 0; i < q.size(); i++) r = crc_step(r, q[i]);
    check({tag, "_residual"}, {16'd0, r}, 32'd0);
  endtask

  // Starts one frame and waits (bounded) for rd_done; cycles = busy cycles up to rd_done.
  task automatic run_frame(input string tag, input bit rnd, output int cycles);
    q.delete();
    done_cnt   = 0;
    max_addr   = 0;
    first_addr = -1;
    stab_err   = 0;
    cycles     = 0;
    unread     = 1'b1;
    tx_permit  = 1'b1;
    tx_ready   = rnd ? ($urandom_range(0, 3) == 0) : 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (rnd) tx_ready = ($urandom_range(0, 3) == 0);
      if (busy) begin
        cycles++;
        unread = 1'b0;
      end
      if (rd_done) break;
    end
    check({tag, "_rd_done_seen"}, {31'd0, rd_done}, 32'd1);
    unread   = 1'b0;
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt, 32'd1);
    check({tag, "_idle_after"}, {30'd0, busy, tx_valid}, 32'd0);
  endtask

  int cyc;

  initial begin
    reset_n   = 1'b0;
    unread    = 1'b0;
    tx_permit = 1'b0;
    abort     = 1'b0;
    tx_ready  = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h5A;

    repeat (3) @(negedge clk);
    check("reset_outs", {rd_addr, tx_data, 4'd0, rd_en, rd_done, tx_valid, busy}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_start", {31'd0, busy}, 32'd0);

    // frame A, no backpressure
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
    mem[3] = 8'hAA; mem[4] = 8'hBB; mem[5] = 8'hCC;
    build_exp();
    run_frame("frameA", 1'b0, cyc);
    compare_stream("frameA");
    check("frameA_latency", cyc, 32'd21);
    check("frameA_first_addr", first_addr, 32'd0);

    // len = 0
    mem[0] = 8'h05; mem[1] = 8'h06; mem[2] = 8'h00;
    build_exp();
    run_frame("len0", 1'b0, cyc);
    compare_stream("len0");
    check("len0_max_addr", max_addr, 32'd2);
    check("len0_latency", cyc, 32'd12);

    // frame A with 25% ready duty
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
    build_exp();
    run_frame("stall", 1'b1, cyc);
    compare_stream("stall");
    check("stall_stability", stab_err, 32'd0);

    // abort on the 4th byte handshake, then retry
    q.delete();
    done_cnt  = 0;
    tx_ready  = 1'b1;
    unread    = 1'b1;
    tx_permit = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_valid && q.size() == 3) break;
    end
    check("abort_reached_byte4", {31'd0, (tx_valid && q.size() == 3)}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    check("abort_outs", {29'd0, tx_valid, busy, rd_en}, 32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt, 32'd0);
    check("abort_stays_idle", {31'd0, busy}, 32'd0);
    abort = 1'b0;
    run_frame("retry", 1'b0, cyc);
    compare_stream("retry");
    check("retry_latency", cyc, 32'd21);

    // oversized len byte
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'hFF;
    for (int i = 3; i < 256; i++) mem[i] = 8'(i * 3 + 1);
    build_exp();
    run_frame("bigLen", 1'b0, cyc);
    compare_stream("bigLen");
    check("bigLen_len_byte", (q.size() > 2) ? {24'd0, q[2]} : 32'hDEAD, 32'hFF);
    check("bigLen_max_addr", max_addr, 32'd255);
    check("bigLen_latency", cyc, 32'd771);

    // reset while stalled in SEND
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
    mem[3] = 8'hAA; mem[4] = 8'hBB; mem[5] = 8'hCC;
    build_exp();
    tx_ready  = 1'b0;
    unread    = 1'b1;
    tx_permit = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_valid) break;
    end
    check("rst_reached_send", {31'd0, tx_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1 check("rst_async_outs", {rd_addr, tx_data, 4'd0, rd_en, rd_done, tx_valid, busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_frame("after_rst", 1'b0, cyc);
    compare_stream("after_rst");
    check("after_rst_first_addr", first_addr, 32'd0);
    check("after_rst_latency", cyc, 32'd21);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
